// File: rtl/riscv_fetch_unit.sv
// riscv_fetch_unit: instruction-fetch front end. Keeps several IMEM requests
// in flight, buffers returned words in an in-order queue for the decoder, and
// on a redirect flushes the queue and silently drops stale in-flight responses.
// Build option: define FETCH_MISALIGN_CHK_EN to flag misaligned redirect
// targets on fetch_err_o and halt fetching until reset.

// Range checks on the internal counters (simulation only).
module riscv_fetch_unit_chk #(
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int CW              = 3
) (
  input logic          clk_i,
  input logic          rst_ni,
  input logic [CW-1:0] outstanding_i,
  input logic [CW-1:0] drop_cnt_i,
  input logic [CW-1:0] count_i
);

  a_outstanding_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
    outstanding_i <= CW'(MAX_OUTSTANDING));

  a_drop_le_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
    drop_cnt_i <= outstanding_i);

  a_count_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_i <= CW'(FIFO_DEPTH));

endmodule

module riscv_fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        redirect_i,
  input  logic [31:0]                 redirect_pc_i,
  output logic [31:0]                 imem_addr_o,
  output logic                        imem_valid_o,
  input  logic                        imem_ready_i,
  input  logic [31:0]                 imem_instr_i,
  input  logic                        imem_valid_i,
  output logic                        imem_ready_o,
  output logic                        if_valid_o,
  input  logic                        if_ready_i,
  output logic [31:0]                 if_pc_o,
  output logic [31:0]                 if_instr_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic                        fetch_err_o
`endif
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int CW1 = CW + 1;
  localparam logic [CW-1:0] CNT_ZERO_C = CW'(0);
  localparam logic [CW-1:0] CNT_ONE_C  = CW'(1);
  localparam logic [CW-1:0] MAX_OS_C   = CW'(MAX_OUTSTANDING);
  localparam logic [CW:0]   DEPTH_C    = CW1'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ZERO_C = AW'(0);
  localparam logic [AW-1:0] PTR_ONE_C  = AW'(1);
  localparam logic [31:0]   PC_STEP_C  = 32'd4;

  // State
  logic [31:0]   r_req_pc;
  logic [31:0]   r_resp_pc;
  logic [31:0]   r_fifo_pc    [FIFO_DEPTH];
  logic [31:0]   r_fifo_instr [FIFO_DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;

  // Combinational helpers
  logic [31:0]   w_target_pc;
  logic          w_halted;
  logic [CW:0]   w_credit_sum;
  logic          w_can_issue;
  logic          w_issue;
  logic          w_resp;
  logic          w_drop_resp;
  logic          w_push;
  logic          w_pop;
  logic          w_not_empty;
  logic [CW-1:0] w_out_nxt;
  logic [CW-1:0] w_drop_nxt;
  logic [CW-1:0] w_count_nxt;

`ifdef FETCH_MISALIGN_CHK_EN
  logic r_halted;
  logic w_misaligned;

  assign w_target_pc  = redirect_pc_i;
  assign w_misaligned = (redirect_pc_i[1:0] != 2'b00);
  assign w_halted     = r_halted;
  assign fetch_err_o  = r_halted;

  // Sticky halt on a misaligned redirect target; only reset clears it.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_halted <= 1'b0;
    end else if (redirect_i && w_misaligned) begin
      r_halted <= 1'b1;
    end else begin
      r_halted <= r_halted;
    end
  end
`else
  // Without the check, a misaligned target is silently word-aligned.
  assign w_target_pc = redirect_pc_i & 32'hFFFF_FFFC;
  assign w_halted    = 1'b0;
`endif

  // Credits count buffered entries plus live (non-stale) in-flight requests,
  // so every accepted response is guaranteed a free FIFO slot.
  assign w_credit_sum = {1'b0, r_count} + {1'b0, r_outstanding} - {1'b0, r_drop_cnt};
  assign w_can_issue  = (r_outstanding < MAX_OS_C) && (w_credit_sum < DEPTH_C);

  assign imem_valid_o = rst_ni && w_can_issue && !redirect_i && !w_halted;
  assign imem_addr_o  = r_req_pc;
  assign imem_ready_o = rst_ni;

  assign w_issue     = imem_valid_o && imem_ready_i;
  assign w_resp      = imem_valid_i && imem_ready_o;
  assign w_drop_resp = w_resp && (r_drop_cnt != CNT_ZERO_C);
  assign w_push      = w_resp && !w_drop_resp && !redirect_i;
  assign w_not_empty = (r_count != CNT_ZERO_C);
  assign w_pop       = w_not_empty && if_ready_i && !redirect_i;

  assign if_valid_o   = w_not_empty;
  assign if_pc_o      = w_not_empty ? r_fifo_pc[r_rd_ptr]    : 32'h0000_0000;
  assign if_instr_o   = w_not_empty ? r_fifo_instr[r_rd_ptr] : 32'h0000_0000;
  assign fifo_count_o = r_count;

  // Next outstanding count: +1 per accepted request, -1 per accepted response.
  always_comb begin
    w_out_nxt = r_outstanding;
    if (w_issue && !w_resp) begin
      w_out_nxt = r_outstanding + CNT_ONE_C;
    end else if (!w_issue && w_resp) begin
      w_out_nxt = r_outstanding - CNT_ONE_C;
    end else begin
      w_out_nxt = r_outstanding;
    end
  end

  // Next drop count: a redirect marks everything still in flight as stale
  // (no request is issued in that cycle, so that is exactly w_out_nxt).
  always_comb begin
    w_drop_nxt = r_drop_cnt;
    if (redirect_i) begin
      w_drop_nxt = w_out_nxt;
    end else if (w_drop_resp) begin
      w_drop_nxt = r_drop_cnt - CNT_ONE_C;
    end else begin
      w_drop_nxt = r_drop_cnt;
    end
  end

  // Next buffer occupancy; a redirect empties the buffer outright.
  always_comb begin
    w_count_nxt = r_count;
    if (redirect_i) begin
      w_count_nxt = CNT_ZERO_C;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_ONE_C;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CNT_ONE_C;
    end else begin
      w_count_nxt = r_count;
    end
  end

  // PCs, pointers and counters.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_req_pc      <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_rd_ptr      <= PTR_ZERO_C;
      r_wr_ptr      <= PTR_ZERO_C;
      r_count       <= CNT_ZERO_C;
      r_outstanding <= CNT_ZERO_C;
      r_drop_cnt    <= CNT_ZERO_C;
    end else begin
      r_count       <= w_count_nxt;
      r_outstanding <= w_out_nxt;
      r_drop_cnt    <= w_drop_nxt;
      if (redirect_i) begin
        r_req_pc  <= w_target_pc;
        r_resp_pc <= w_target_pc;
        r_rd_ptr  <= PTR_ZERO_C;
        r_wr_ptr  <= PTR_ZERO_C;
      end else begin
        if (w_issue) begin
          r_req_pc <= r_req_pc + PC_STEP_C;
        end
        if (w_push) begin
          r_resp_pc <= r_resp_pc + PC_STEP_C;
          r_wr_ptr  <= r_wr_ptr + PTR_ONE_C;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_ONE_C;
        end
      end
    end
  end

  // Instruction buffer storage: write {pc, instr} at the tail on push.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_pc[i]    <= 32'h0000_0000;
        r_fifo_instr[i] <= 32'h0000_0000;
      end
    end else if (w_push) begin
      r_fifo_pc[r_wr_ptr]    <= r_resp_pc;
      r_fifo_instr[r_wr_ptr] <= imem_instr_i;
    end else begin
      r_fifo_pc[r_wr_ptr]    <= r_fifo_pc[r_wr_ptr];
      r_fifo_instr[r_wr_ptr] <= r_fifo_instr[r_wr_ptr];
    end
  end

  riscv_fetch_unit_chk #(
    .FIFO_DEPTH      (FIFO_DEPTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CW              (CW)
  ) u_chk (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .outstanding_i (r_outstanding),
    .drop_cnt_i    (r_drop_cnt),
    .count_i       (r_count)
  );

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// tb_riscv_fetch_unit: randomized IMEM/decoder environment around the fetch
// unit, checked every cycle against a queue-based reference model, plus a
// second instance with RESET_PC near the top of the address space.
module tb_riscv_fetch_unit;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;
  localparam logic [31:0] RPC2 = 32'hFFFF_FFF8;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic [31:0] addr; int cyc; bit stale; } req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic        imem_valid_o;
  logic        imem_ready_i;
  logic [31:0] imem_instr;
  logic        imem_valid_i;
  logic        imem_ready_o;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [2:0]  fifo_count;
  logic        fetch_err;

  logic        redirect2 = 1'b0;
  logic [31:0] redirect_pc2 = 32'h0;
  logic [31:0] imem_addr2;
  logic        imem_valid_o2;
  logic        imem_ready_i2 = 1'b1;
  logic [31:0] imem_instr2;
  logic        imem_valid_i2;
  logic        imem_ready_o2;
  logic        if_valid2;
  logic        if_ready2 = 1'b1;
  logic [31:0] if_pc2;
  logic [31:0] if_instr2;
  logic [2:0]  fifo_count2;
  logic        fetch_err2;

  riscv_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_addr_o(imem_addr), .imem_valid_o(imem_valid_o), .imem_ready_i(imem_ready_i),
    .imem_instr_i(imem_instr), .imem_valid_i(imem_valid_i), .imem_ready_o(imem_ready_o),
    .if_valid_o(if_valid), .if_ready_i(if_ready), .if_pc_o(if_pc), .if_instr_o(if_instr),
    .fifo_count_o(fifo_count)
`ifdef FETCH_MISALIGN_CHK_EN
    , .fetch_err_o(fetch_err)
`endif
  );

  riscv_fetch_unit #(.RESET_PC(RPC2), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .redirect_i(redirect2), .redirect_pc_i(redirect_pc2),
    .imem_addr_o(imem_addr2), .imem_valid_o(imem_valid_o2), .imem_ready_i(imem_ready_i2),
    .imem_instr_i(imem_instr2), .imem_valid_i(imem_valid_i2), .imem_ready_o(imem_ready_o2),
    .if_valid_o(if_valid2), .if_ready_i(if_ready2), .if_pc_o(if_pc2), .if_instr_o(if_instr2),
    .fifo_count_o(fifo_count2)
`ifdef FETCH_MISALIGN_CHK_EN
    , .fetch_err_o(fetch_err2)
`endif
  );

`ifndef FETCH_MISALIGN_CHK_EN
  assign fetch_err  = 1'b0;
  assign fetch_err2 = 1'b0;
`endif

  // Reference model state
  ent_t        q[$];        // what the decoder must see, head first
  req_t        pend[$];     // requests IMEM has accepted, in order
  logic [31:0] nreq;        // next address that must be requested
  logic [31:0] nresp;       // PC of the next instruction to be delivered
  bit          halted;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] delivered[$];
  logic [31:0] del2_pc[$];
  logic [31:0] del2_instr[$];
  int          p_rdy, p_resp, p_dec, p_redir;
  bit          force_redir = 1'b0;
  logic [31:0] force_tgt;
  bit          phase1 = 1'b0;
  bit          p2_valid = 1'b0;
  logic [31:0] p2_addr = 32'h0;

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] eff_target(input logic [31:0] t);
`ifdef FETCH_MISALIGN_CHK_EN
    return t;
`else
    return t & 32'hFFFF_FFFC;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%b required=%b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic rand_target(output logic [31:0] t);
    t = $urandom();
`ifdef FETCH_MISALIGN_CHK_EN
    t = t & 32'hFFFF_FFFC;
`endif
    if ($urandom_range(9) == 0) t = 32'hFFFF_FFF0 | (t & 32'h0000_000F);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ready_i = 1'b0; imem_valid_i = 1'b0; imem_instr = 32'h0; if_ready = 1'b0;
    imem_valid_i2 = 1'b0; imem_instr2 = 32'h0;
    @(posedge clk); #1;
    check1("rst_imem_valid", imem_valid_o, 1'b0);
    check1("rst_imem_ready", imem_ready_o, 1'b0);
    check1("rst_if_valid", if_valid, 1'b0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_addr2", imem_addr2, RPC2);
    check1("rst_imem_ready2", imem_ready_o2, 1'b0);
    check("rst_count2", {29'd0, fifo_count2}, 32'd0);
    check1("rst_fetch_err", fetch_err | fetch_err2, 1'b0);
    @(posedge clk); @(negedge clk);
    q.delete(); pend.delete();
    nreq = 32'h0; nresp = 32'h0; halted = 1'b0;
    p2_valid = 1'b0; p2_addr = 32'h0;
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive at negedge, compare, then advance the model.
  task automatic cycle();
    bit do_redir, iss_hs, resp_hs, pop_hs, exp_v, iss2;
    logic [31:0] tgt, addr_cap, addr2_cap;
    int stale_n;
    req_t r;
    ent_t e;
    if (force_redir) begin
      do_redir = 1'b1; tgt = force_tgt;
    end else begin
      do_redir = ($urandom_range(99) < p_redir); rand_target(tgt);
    end
    force_redir = 1'b0;
    redirect = do_redir; redirect_pc = tgt;
    imem_ready_i = ($urandom_range(99) < p_rdy);
    imem_valid_i = 1'b0;
    imem_instr = $urandom();
    if (pend.size() > 0) begin
      if (pend[0].cyc < cyc && $urandom_range(99) < p_resp) begin
        imem_valid_i = 1'b1;
        imem_instr = word_at(pend[0].addr);
      end
    end
    if_ready = ($urandom_range(99) < p_dec);
    imem_valid_i2 = p2_valid; imem_instr2 = word_at(p2_addr);
    #1;
    stale_n = 0;
    foreach (pend[i]) if (pend[i].stale) stale_n++;
    exp_v = !do_redir && !halted && (pend.size() < MAXO) &&
            (q.size() + pend.size() - stale_n < DEPTH);
    check1("imem_valid", imem_valid_o, exp_v);
    check("imem_addr", imem_addr, nreq);
    check1("imem_ready", imem_ready_o, 1'b1);
    check1("if_valid", if_valid, q.size() > 0);
    if (q.size() > 0) begin
      check("if_pc", if_pc, q[0].pc);
      check("if_instr", if_instr, q[0].instr);
    end
    check("fifo_count", {29'd0, fifo_count}, q.size());
`ifdef FETCH_MISALIGN_CHK_EN
    check1("fetch_err", fetch_err, halted);
`endif
    if (phase1) check1("t1_count_le1", fifo_count <= 3'd1, 1'b1);
    iss_hs = imem_valid_o && imem_ready_i;
    resp_hs = imem_valid_i;
    pop_hs = if_valid && if_ready && !do_redir;
    addr_cap = imem_addr;
    if (pop_hs) delivered.push_back(if_pc);
    iss2 = imem_valid_o2;
    addr2_cap = imem_addr2;
    if (if_valid2 && del2_pc.size() < 3) begin
      del2_pc.push_back(if_pc2); del2_instr.push_back(if_instr2);
    end
    @(posedge clk);
    if (pop_hs && q.size() > 0) void'(q.pop_front());
    if (resp_hs) begin
      r = pend.pop_front();
      if (!r.stale && !do_redir) begin
        e.pc = nresp; e.instr = word_at(nresp);
        q.push_back(e);
        nresp = nresp + 32'd4;
      end
    end
    if (iss_hs) begin
      r.addr = addr_cap; r.cyc = cyc; r.stale = 1'b0;
      pend.push_back(r);
      if (!do_redir) nreq = nreq + 32'd4;
    end
    if (do_redir) begin
      q.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
      nreq = eff_target(tgt); nresp = eff_target(tgt);
`ifdef FETCH_MISALIGN_CHK_EN
      if (tgt[1:0] != 2'b00) halted = 1'b1;
`endif
    end
    p2_valid = iss2; p2_addr = addr2_cap;
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int idx;
    logic [31:0] got;
    do_reset();

    // 1: everything always ready, no redirects
    p_rdy = 100; p_resp = 100; p_dec = 100; p_redir = 0;
    phase1 = 1'b1;
    repeat (30) cycle();
    phase1 = 1'b0;
    check("t1_pc0", delivered[0], 32'h0000_0000);
    check("t1_pc1", delivered[1], 32'h0000_0004);
    check("t1_pc2", delivered[2], 32'h0000_0008);
    // 5: second instance wraps past the top of the address space
    check("t5_pc0", del2_pc[0], 32'hFFFF_FFF8);
    check("t5_pc1", del2_pc[1], 32'hFFFF_FFFC);
    check("t5_pc2", del2_pc[2], 32'h0000_0000);
    check("t5_instr2", del2_instr[2], word_at(32'h0000_0000));

    // 2: decoder stalled, buffer fills and fetch stops
    p_dec = 0;
    repeat (20) cycle();
    check("t2_count_full", {29'd0, fifo_count}, 32'd4);
    check1("t2_no_issue", imem_valid_o, 1'b0);
    p_dec = 100;
    repeat (10) cycle();

    // 3: redirect to 0x100 with responses held back
    p_resp = 0;
    repeat (3) cycle();
    p_resp = 100;
    force_redir = 1'b1; force_tgt = 32'h0000_0100;
    idx = delivered.size();
    cycle();
    check("t3_count_after", {29'd0, fifo_count}, 32'd0);
    repeat (10) cycle();
    got = 32'hFFFF_FFFF;
    if (delivered.size() > idx) got = delivered[idx];
    check("t3_first_pc", got, 32'h0000_0100);

    // 4: redirect coinciding with a response and a decoder pop
    p_dec = 0;
    repeat (3) cycle();
    p_dec = 100;
    force_redir = 1'b1; force_tgt = 32'h0000_0200;
    idx = delivered.size();
    cycle();
    check("t4_count_after", {29'd0, fifo_count}, 32'd0);
    repeat (10) cycle();
    got = 32'hFFFF_FFFF;
    if (delivered.size() > idx) got = delivered[idx];
    check("t4_first_pc", got, 32'h0000_0200);

    // Randomized traffic with redirects
    for (int blk = 0; blk < 12; blk++) begin
      p_rdy = $urandom_range(100, 20); p_resp = $urandom_range(100, 20);
      p_dec = $urandom_range(100, 10); p_redir = 5;
      repeat (50) cycle();
    end

    // Reset in mid-operation, then more traffic
    do_reset();
    repeat (100) cycle();

`ifdef FETCH_MISALIGN_CHK_EN
    // 6: misaligned redirect halts fetch until reset
    p_redir = 0;
    force_redir = 1'b1; force_tgt = 32'h0000_0102;
    cycle();
    check1("t6_err_set", fetch_err, 1'b1);
    for (int i = 0; i < 50; i++) begin
      cycle();
      check1("t6_halted_valid", imem_valid_o, 1'b0);
    end
    do_reset();
    check1("t6_err_cleared", fetch_err, 1'b0);
    p_rdy = 100; p_resp = 100; p_dec = 100;
    repeat (20) cycle();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
